// File: rtl/bcd_to_bin_14b_pkg.sv
// Shared definitions for the BCD-to-binary converter.
// Holds the FSM state encoding, the blank-digit code, the range limits
// and the sel mode codes. The display converter uses the same mode codes,
// so both directions interpret sel in the same way.
package bcd_to_bin_14b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK = 4'hF;

    localparam int unsigned MAX_8B  = 255;
    localparam int unsigned MAX_7B  = 99;
    localparam int unsigned MAX_14B = 9999;

    typedef enum logic [1:0] {
        MODE_8B      = 2'd0,
        MODE_7B      = 2'd1,
        MODE_14B     = 2'd2,
        MODE_14B_ALT = 2'd3
    } mode_t;

    // Upper bound of the legal result for a given mode select.
    function automatic int unsigned range_max(input logic [1:0] sel);
        int unsigned lim;
        case (mode_t'(sel))
            MODE_8B:  lim = MAX_8B;
            MODE_7B:  lim = MAX_7B;
            default:  lim = MAX_14B;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/bcd_to_bin_14b_if.sv
// Handshake/data bundle between digit-entry logic (master) and the
// BCD-to-binary converter (slave).
//   start  : request a conversion (master -> slave)
//   sel    : range mode select
//   d3..d0 : thousands..units BCD digits, 4'hF = blank leading zero
//   bin    : converted value, held until the next done
//   busy   : conversion in progress
//   done   : one-cycle pulse when bin/err update
//   err    : conversion error, held until the next done
interface bcd_to_bin_14b_if
    import bcd_to_bin_14b_pkg::*;
#(
    parameter int W = 14
);
    logic          start;
    logic [1:0]    sel;
    bcd_digit_t    d3;
    bcd_digit_t    d2;
    bcd_digit_t    d1;
    bcd_digit_t    d0;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, sel, d3, d2, d1, d0,
        input  bin, busy, done, err
    );

    modport slave (
        input  start, sel, d3, d2, d1, d0,
        output bin, busy, done, err
    );

endinterface

// File: rtl/bcd_to_bin_14b_digit_chk.sv
// Combinational check of one BCD digit while scanning from the most
// significant digit down.
//   digit              : digit code (0-9 valid, 4'hF blank)
//   seen_nonblank      : a non-blank digit has already been processed
//   is_last            : this is the units digit, which may not be blank
//   value              : contribution to the accumulator (0 for blank/illegal)
//   invalid            : digit is illegal in this position
//   seen_nonblank_next : updated seen_nonblank for the next digit
module bcd_to_bin_14b_digit_chk
    import bcd_to_bin_14b_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       seen_nonblank,
    input  logic       is_last,
    output logic [3:0] value,
    output logic       invalid,
    output logic       seen_nonblank_next
);

    always_comb begin
        value              = 4'd0;
        invalid            = 1'b0;
        seen_nonblank_next = seen_nonblank;
        if (digit == BLANK) begin
            // Blanks are only legal as leading zeros, never in the units place.
            invalid = seen_nonblank | is_last;
        end else if (digit > 4'd9) begin
            invalid            = 1'b1;
            seen_nonblank_next = 1'b1;
        end else begin
            value              = digit;
            seen_nonblank_next = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_to_bin_14b.sv
// Sequential 4-digit BCD to binary converter, one digit per clock.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of bcd_to_bin_14b_if (start/sel/digits in,
//           bin/busy/done/err out)
// A start in IDLE latches the digits and mode; four ACC cycles fold the
// digits into acc (acc*10 + digit), then CHK applies the range limit and
// publishes bin/err with a one-cycle done pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for start; bin/err hold the last result
//   ACC     | folding digit[idx] into acc, idx counts 3 down to 0
//   CHK     | range check, register bin/err, pulse done
module bcd_to_bin_14b
    import bcd_to_bin_14b_pkg::*;
#(
    parameter int W       = 14,
    parameter int LAT_CHK = 1
)(
    input  logic               clk,
    input  logic               reset,
    bcd_to_bin_14b_if.slave    bus
);

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [3:0][3:0]  dig_q, dig_n;
    logic [1:0]       sel_q, sel_n;
    logic [W-1:0]     acc, acc_n;
    logic             err_stk, err_stk_n;
    logic             seen_nb, seen_nb_n;
    logic [1:0]       chk_tmr, chk_tmr_n;
    logic [W-1:0]     bin_q, bin_n;
    logic             err_q, err_n;
    logic             done_q, done_n;

    logic [3:0]       dg_val;
    logic             dg_bad;
    logic             dg_seen;
    logic             over;

    bcd_to_bin_14b_digit_chk u_digit_chk (
        .digit              (dig_q[idx]),
        .seen_nonblank      (seen_nb),
        .is_last            (idx == 2'd0),
        .value              (dg_val),
        .invalid            (dg_bad),
        .seen_nonblank_next (dg_seen)
    );

    assign over = (32'(acc) > range_max(sel_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= 2'd0;
            dig_q   <= '0;
            sel_q   <= 2'd0;
            acc     <= '0;
            err_stk <= 1'b0;
            seen_nb <= 1'b0;
            chk_tmr <= 2'd0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            dig_q   <= dig_n;
            sel_q   <= sel_n;
            acc     <= acc_n;
            err_stk <= err_stk_n;
            seen_nb <= seen_nb_n;
            chk_tmr <= chk_tmr_n;
            bin_q   <= bin_n;
            err_q   <= err_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        dig_n     = dig_q;
        sel_n     = sel_q;
        acc_n     = acc;
        err_stk_n = err_stk;
        seen_nb_n = seen_nb;
        chk_tmr_n = chk_tmr;
        bin_n     = bin_q;
        err_n     = err_q;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    dig_n     = {bus.d3, bus.d2, bus.d1, bus.d0};
                    sel_n     = bus.sel;
                    acc_n     = '0;
                    idx_n     = 2'd3;
                    err_stk_n = 1'b0;
                    seen_nb_n = 1'b0;
                    state_n   = ST_ACC;
                end
            end

            ST_ACC: begin
                // acc*10 as shift-add; max intermediate 999*10+9 fits in W bits.
                acc_n     = (acc << 3) + (acc << 1) + W'(dg_val);
                err_stk_n = err_stk | dg_bad;
                seen_nb_n = dg_seen;
                if (idx == 2'd0) begin
                    chk_tmr_n = 2'(LAT_CHK - 1);
                    state_n   = ST_CHK;
                end else begin
                    idx_n = idx - 2'd1;
                end
            end

            ST_CHK: begin
                if (chk_tmr == 2'd0) begin
                    if (err_stk || over) begin
                        bin_n = '0;
                        err_n = 1'b1;
                    end else begin
                        bin_n = acc;
                        err_n = 1'b0;
                    end
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    chk_tmr_n = chk_tmr - 2'd1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_to_bin_14b.sv
// Self-checking bench for bcd_to_bin_14b: directed vectors with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_bcd_to_bin_14b;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd_to_bin_14b_if #(.W(14)) bus ();

    bcd_to_bin_14b #(.W(14), .LAT_CHK(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal value from positional weights, legality from the
    // leading-blank rule, then the mode range limit.
    function automatic void model(input logic [1:0] s,
                                  input logic [3:0] a, b, c, d,
                                  output int rbin, output int rerr);
        logic [3:0] dg [4];
        int pw [4];
        int v;
        bit bad;
        bit started;
        int lim;
        dg[0] = a; dg[1] = b; dg[2] = c; dg[3] = d;
        pw[0] = 1000; pw[1] = 100; pw[2] = 10; pw[3] = 1;
        v = 0; bad = 0; started = 0;
        for (int i = 0; i < 4; i++) begin
            if (dg[i] == 4'hF) begin
                if (started || i == 3) bad = 1;
            end else if (dg[i] > 4'd9) begin
                bad = 1;
                started = 1;
            end else begin
                started = 1;
                v = v + int'(dg[i]) * pw[i];
            end
        end
        lim = (s == 2'd0) ? 255 : (s == 2'd1) ? 99 : 9999;
        if (bad || v > lim) begin
            rbin = 0; rerr = 1;
        end else begin
            rbin = v; rerr = 0;
        end
    endfunction

    // Cycle-level expectation: a conversion occupies 5 busy cycles, then a
    // done cycle in which a new start may be taken.
    int m_cnt  = 0;
    int m_bin  = 0;
    int m_err  = 0;
    int m_done = 0;
    int p_bin  = 0;
    int p_err  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_bin = 0; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1; m_bin = p_bin; m_err = p_err;
                end
            end else if (bus.start) begin
                model(bus.sel, bus.d3, bus.d2, bus.d1, bus.d0, p_bin, p_err);
                m_cnt = 5;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_done", int'(bus.done), m_done);
        check("cyc_busy", int'(bus.busy), (m_cnt != 0) ? 1 : 0);
        check("cyc_bin",  int'(bus.bin),  m_bin);
        check("cyc_err",  int'(bus.err),  m_err);
    end

    task automatic run(input string name, input logic [1:0] s,
                       input logic [3:0] a, b, c, d,
                       input int eb, input int ee);
        int lat;
        bit got;
        @(negedge clk);
        bus.sel = s; bus.d3 = a; bus.d2 = b; bus.d1 = c; bus.d0 = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; got = 0;
        while (!got && lat < 20) begin
            if (bus.done) got = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_lat"}, lat, 6);
        check({name, "_bin"}, int'(bus.bin), eb);
        check({name, "_err"}, int'(bus.err), ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, re, t, ndone;
        bus.start = 1'b0; bus.sel = 2'd2;
        bus.d3 = 4'd0; bus.d2 = 4'd0; bus.d1 = 4'd0; bus.d0 = 4'd0;

        // Hand-computed pins on the reference model.
        model(2'd2, 4'hF, 4'hF, 4'd4, 4'd2, rb, re);
        check("mdl_ff42_bin", rb, 42);  check("mdl_ff42_err", re, 0);
        model(2'd1, 4'hF, 4'd1, 4'd0, 4'd0, rb, re);
        check("mdl_f100_bin", rb, 0);   check("mdl_f100_err", re, 1);
        model(2'd0, 4'hF, 4'd2, 4'd5, 4'd5, rb, re);
        check("mdl_f255_bin", rb, 255); check("mdl_f255_err", re, 0);

        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_bin",  int'(bus.bin),  0);
        check("rst_err",  int'(bus.err),  0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b0;

        run("r9999",  2'd2, 4'd9, 4'd9, 4'd9, 4'd9, 9999, 0);
        run("r255",   2'd0, 4'hF, 4'd2, 4'd5, 4'd5, 255, 0);
        run("r256",   2'd0, 4'hF, 4'd2, 4'd5, 4'd6, 0, 1);
        run("r7",     2'd1, 4'hF, 4'hF, 4'hF, 4'd7, 7, 0);
        run("r99",    2'd1, 4'hF, 4'hF, 4'd9, 4'd9, 99, 0);
        run("r100",   2'd1, 4'hF, 4'd1, 4'd0, 4'd0, 0, 1);
        run("r1f34",  2'd2, 4'd1, 4'hF, 4'd3, 4'd4, 0, 1);
        run("rffff",  2'd2, 4'hF, 4'hF, 4'hF, 4'hF, 0, 1);
        run("r0a00",  2'd2, 4'd0, 4'hA, 4'd0, 4'd0, 0, 1);
        run("rffc1",  2'd2, 4'hF, 4'hF, 4'hC, 4'd1, 0, 1);
        run("r0000",  2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0);
        run("r4096",  2'd2, 4'd4, 4'd0, 4'd9, 4'd6, 4096, 0);
        run("rs3",    2'd3, 4'd9, 4'd9, 4'd9, 4'd8, 9998, 0);

        // Start held high; digits change mid-conversion.
        @(negedge clk);
        bus.sel = 2'd2; bus.d3 = 4'd1; bus.d2 = 4'd2; bus.d1 = 4'd3; bus.d0 = 4'd4;
        bus.start = 1'b1;
        t = 0;
        repeat (2) begin @(negedge clk); t++; end
        bus.d3 = 4'd5; bus.d2 = 4'd6; bus.d1 = 4'd7; bus.d0 = 4'd8;
        while (!bus.done && t < 20) begin @(negedge clk); t++; end
        check("hs1_lat", t, 6);
        check("hs1_bin", int'(bus.bin), 1234);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.done && t < 20);
        bus.start = 1'b0;
        check("hs2_gap", t, 6);
        check("hs2_bin", int'(bus.bin), 5678);
        repeat (3) @(negedge clk);

        // Async reset during ACC with idx = 1 (after the second ACC edge).
        bus.sel = 2'd2; bus.d3 = 4'd9; bus.d2 = 4'd9; bus.d1 = 4'd9; bus.d0 = 4'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_bin",  int'(bus.bin),  0);
        check("arst_err",  int'(bus.err),  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("arst_nodone", ndone, 0);
        run("r0042", 2'd2, 4'd0, 4'd0, 4'd4, 4'd2, 42, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_14b.md
Name: bcd_to_bin_14b

Overview:
Sequential converter from a 4-digit BCD display-format value back to 14-bit binary. It is the inverse of the multiplier's binary-to-decimal display path. Digit encoding matches the display side: 0-9 are valid, 4'hF is a blanked leading zero, and the same 2-bit mode select applies. It sits between the digit-entry logic (keypad/switch digits) and the multiplier operand registers. It converts one digit per clock with a start/done handshake.

Parameters:
W, 14, binary result width; must hold 9999.
LAT_CHK, 1, number of range-check cycles after accumulation; fixed at 1 and not intended for override.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request conversion; sampled only in IDLE
sel  in  2  mode: 0 = [0,255], 1 = [0,99], 2 = [0,9999], 3 = same as 2
d3  in  4  1000's digit (0-9 or 4'hF blank)
d2  in  4  100's digit
d1  in  4  10's digit
d0  in  4  1's digit (0-9 only)
bin  out  14  converted value; holds until next done
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when bin/err update
err  out  1  conversion error flag; holds until next done

Behaviour:
- Reset (async): state=IDLE; bin=0, err=0, done=0, busy=0; internal accumulator and digit latches cleared. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states: IDLE, ACC, CHK.
  - IDLE: on start=1 at edge N, latch d3..d0 and sel, set acc=0 and idx=3, then go to ACC. Otherwise remain.
  - ACC: at edges N+1..N+4, process digit[idx] with acc <= acc*10 + digit (acc*10 = (acc<<3)+(acc<<1)). A blank digit contributes 0. idx decrements. After idx=0, go to CHK.
  - CHK: at edge N+5, register bin, err and done=1, then return to IDLE.
- Latency: done is high for exactly the cycle after edge N+5. busy is high after edge N through edge N+5. A new start is accepted on the cycle done is high, which is the first cycle back in IDLE.
- start while busy is ignored. Input digit changes while busy are ignored because digits are latched.
- Digit validity sets err=1 and bin=0 for any of:
  - any digit in 10..14;
  - d0 = 4'hF;
  - a blank digit following a non-blank digit, e.g. d3=1, d2=F.
- Leading blanks are legal: F,F,4,2 yields 42. All-zero digits 0,0,0,0 yield 0 with err=0.
- Range check in CHK: max is 255 for sel=0, 99 for sel=1, and 9999 for sel=2/3. If acc > max, then err=1 and bin=0.
- Width: 14-bit acc is sufficient because the maximum intermediate value is 999*10+9. No overflow path exists.
- Error flags accumulate during ACC in a sticky bit, cleared at start acceptance.
- done is never asserted in consecutive cycles.

Decomposition:
- Shared package (multiplier_pkg):
  - state encoding (IDLE/ACC/CHK)
  - BLANK = 4'hF
  - MAX_8B = 255, MAX_7B = 99, MAX_14B = 9999
  - mode codes for sel 0..3; shared with the display converter so both directions agree on mode meaning
- One sub-module is natural: bcd_digit_chk. It is combinational and takes a digit plus a seen_nonblank flag. It outputs the digit value (0 for blank), an invalid flag, and the next seen_nonblank.

Test Plan:
- sel=2, digits 9,9,9,9, start pulse at edge N -> busy high for N+1..N+5; done pulse after edge N+5; bin=9999, err=0.
- sel=0, digits F,2,5,5 -> bin=255, err=0. Then digits F,2,5,6 -> bin=0, err=1 (over range for 8-bit mode).
- sel=1, digits F,F,F,7 -> bin=7. Then digits F,1,0,0 -> err=1, bin=0 (exceeds 99).
- sel=2, illegal encodings: digits 1,F,3,4 -> err=1; digits F,F,F,F -> err=1 (d0 blank); digits 0,A,0,0 -> err=1.
- Handshake: start held high continuously with digits 1,2,3,4 then changed to 5,6,7,8 mid-conversion -> first done gives bin=1234. The next start is accepted in the done cycle, and done pulses exactly every 6 cycles with bin=5678.
- Reset asserted asynchronously during ACC at idx=1 -> outputs immediately 0 and state IDLE, with no done. After release, start with 0,0,4,2 -> bin=42.
